matrix_scan_ctrl: RTL and testbench



---
 rtl/matrix_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl.sv
// Row-multiplexed refresh controller for a 16x16 LED matrix.
// It scans the matrix one row at a time and inserts a blanking gap between
// rows. Incoming frames are double-buffered, and the buffers swap only at
// frame boundaries so that no displayed frame is ever torn. Every
// FRAMES_PER_GEN refresh frames it pulses step_req to pace the Life engine.
//
// frame_valid / frame_ready handshake:
//   A frame transfers on any cycle where frame_valid && frame_ready is
//   sampled high at the rising edge. frame_ready is high exactly when the
//   shadow buffer is empty. While frame_ready is low the source must hold
//   frame_in stable, and frame_valid has no effect.
module matrix_scan_ctrl #(
    parameter int ROW_DWELL      = 1000,
    parameter int BLANK          = 16,
    parameter int FRAMES_PER_GEN = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [255:0] frame_in,
    input  logic         frame_valid,
    output logic         frame_ready,
    output logic         step_req,
    output logic         frame_start,
    output logic [15:0]  R,
    output logic [15:0]  C,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_e;

    // A single dwell counter serves both the BLANK and SHOW phases,
    // so it is sized for the longer of the two.
    localparam int DWELL_MAX = (ROW_DWELL > BLANK) ? ROW_DWELL : BLANK;
    localparam int CNT_W     = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;
    localparam int FRM_W     = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(ROW_DWELL - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(FRAMES_PER_GEN - 1);

    state_e             state_q;
    logic [3:0]         row_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRM_W-1:0]   frm_q;
    logic [15:0]        r_q;
    logic [15:0]        c_q;
    logic               step_q;
    logic               fstart_q;

    logic [255:0]       display_q, display_d;
    logic [255:0]       shadow_q, shadow_d;
    logic               pending_q, pending_d;
    logic               ready_q;

    logic               accept;
    logic               frame_end;
    logic               swap;

    assign R           = r_q;
    assign C           = c_q;
    assign step_req    = step_q;
    assign frame_start = fstart_q;
    assign frame_ready = ready_q;
    assign dbg_state_o = state_q;

    // Buffer control. A swap needs pending=1 and an accept needs pending=0,
    // so the two can never happen in the same cycle.
    always_comb begin
        accept    = frame_valid && !pending_q;
        frame_end = enable && (state_q == S_SHOW) && (row_q == 4'd15)
                    && (cnt_q == SHOW_LAST);
        swap      = pending_q && (frame_end || (state_q == S_IDLE));
        pending_d = pending_q;
        display_d = display_q;
        shadow_d  = shadow_q;
        if (swap) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end else if (accept) begin
            shadow_d  = frame_in;
            pending_d = 1'b1;
        end
    end

    // Double-buffer registers. frame_ready tracks the next pending value,
    // so it always equals !pending and a second frame cannot slip in.
    always_ff @(posedge clk) begin
        if (rst) begin
            display_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            display_q <= display_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ready_q   <= !pending_d;
        end
    end

    // Scan FSM. Outputs are registered together with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= 4'd0;
            cnt_q    <= '0;
            frm_q    <= '0;
            r_q      <= 16'hFFFF;
            c_q      <= 16'h0000;
            step_q   <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            step_q   <= 1'b0;
            fstart_q <= 1'b0;
            if (!enable) begin
                // Disabling blanks immediately and restarts the scan at row 0.
                // The frame pacing count is kept.
                state_q <= S_IDLE;
                row_q   <= 4'd0;
                cnt_q   <= '0;
                r_q     <= 16'hFFFF;
                c_q     <= 16'h0000;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_BLANK;
                        row_q   <= 4'd0;
                        cnt_q   <= '0;
                        r_q     <= 16'hFFFF;
                        c_q     <= 16'h0000;
                    end
                    S_BLANK: begin
                        if (cnt_q == BLANK_LAST) begin
                            state_q  <= S_SHOW;
                            cnt_q    <= '0;
                            r_q      <= ~(16'h0001 << row_q);
                            c_q      <= display_q[{row_q, 4'b0000} +: 16];
                            fstart_q <= (row_q == 4'd0);
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_SHOW: begin
                        if (cnt_q == SHOW_LAST) begin
                            state_q <= S_BLANK;
                            cnt_q   <= '0;
                            row_q   <= row_q + 1'b1;
                            r_q     <= 16'hFFFF;
                            c_q     <= 16'h0000;
                            if (row_q == 4'd15) begin
                                if (frm_q == FRM_LAST) begin
                                    frm_q  <= '0;
                                    step_q <= 1'b1;
                                end else begin
                                    frm_q <= frm_q + 1'b1;
                                end
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        row_q   <= 4'd0;
                        cnt_q   <= '0;
                        r_q     <= 16'hFFFF;
                        c_q     <= 16'h0000;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl with ROW_DWELL=4, BLANK=2, FRAMES_PER_GEN=3.
module tb_matrix_scan_ctrl;
  localparam int ROW_DWELL = 4;
  localparam int BLANK     = 2;
  localparam int FPG       = 3;
  localparam int SLOT      = BLANK + ROW_DWELL;
  localparam int FRAME     = 16 * SLOT;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         frame_valid = 1'b0;
  logic [255:0] frame_in = '0;
  logic         frame_ready, step_req, frame_start;
  logic [15:0]  R, C;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  matrix_scan_ctrl #(
    .ROW_DWELL(ROW_DWELL),
    .BLANK(BLANK),
    .FRAMES_PER_GEN(FPG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .frame_in(frame_in),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .step_req(step_req),
    .frame_start(frame_start),
    .R(R),
    .C(C),
    .dbg_state_o(dbg_state)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  // The scan is described by the number of cycles since scanning started:
  // slot = ph % SLOT (BLANK then SHOW), row = ph / SLOT.
  logic         m_run = 1'b0;
  logic         m_pend = 1'b0;
  logic         m_step = 1'b0;
  int           m_ph = 0;
  int           m_frm = 0;
  logic [255:0] m_disp = '0;
  logic [255:0] m_shadow = '0;

  task automatic model_update(input logic r, input logic e, input logic v, input logic [255:0] d);
    logic fe, acc;
    if (r) begin
      m_run = 1'b0; m_ph = 0; m_frm = 0; m_pend = 1'b0;
      m_disp = '0; m_shadow = '0; m_step = 1'b0;
    end else begin
      fe  = m_run && e && (m_ph % SLOT == SLOT - 1) && ((m_ph / SLOT) % 16 == 15);
      acc = v && !m_pend;
      m_step = 1'b0;
      if (fe) begin
        if (m_frm == FPG - 1) begin m_frm = 0; m_step = 1'b1; end
        else m_frm = m_frm + 1;
      end
      if (m_pend && (fe || !m_run)) begin
        m_disp = m_shadow; m_pend = 1'b0;
      end else if (acc) begin
        m_shadow = d; m_pend = 1'b1;
      end
      if (!e) begin m_run = 1'b0; m_ph = 0; end
      else if (!m_run) begin m_run = 1'b1; m_ph = 0; end
      else m_ph = (m_ph + 1) % FRAME;
    end
  endtask

  task automatic check_model();
    int slot, row;
    logic [15:0] er, ec;
    logic erdy, efs;
    slot = m_ph % SLOT;
    row  = (m_ph / SLOT) % 16;
    er = 16'hFFFF; ec = 16'h0000;
    if (m_run && slot >= BLANK) begin
      er = ~(16'h0001 << row);
      ec = m_disp[16*row +: 16];
    end
    erdy = !m_pend;
    efs  = m_run && (slot == BLANK) && (row == 0);
    n_vec++;
    if (R !== er || C !== ec || frame_ready !== erdy || step_req !== m_step || frame_start !== efs) begin
      n_bad++;
      $display("FAIL model cyc %0d: R=%h C=%h rdy=%b step=%b fs=%b, required R=%h C=%h rdy=%b step=%b fs=%b",
               cyc, R, C, frame_ready, step_req, frame_start, er, ec, erdy, m_step, efs);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic r, input logic e, input logic v, input logic [255:0] d);
    rst = r; enable = e; frame_valid = v; frame_in = d;
    @(posedge clk);
    model_update(r, e, v, d);
    @(negedge clk);
    cyc++;
    check_model();
    n_vec++;
    if ($countones(~R) > 1) begin
      n_bad++;
      $display("FAIL one_row_low cyc %0d: R=%h, required at most one low bit", cyc, R);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %h, required %h", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_row(input int r, input string nm);
    int k;
    logic [15:0] tgt;
    tgt = ~(16'h0001 << r);
    k = 0;
    while (R !== tgt && k < 300) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      k++;
    end
    chk(nm, R, tgt);
  endtask

  function automatic logic [255:0] rand_frame();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[32*i +: 32] = $urandom();
    return f;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, en, v;
    logic [15:0] r, c;
    logic        rdy, st, fs;
  } vec_t;

  vec_t tbl[19];

  // ---------------- test sequence ----------------
  initial begin
    logic [255:0] diag, fa, fb, fc;
    logic [15:0]  prev_r;
    int k, nstep, nfs;
    logic saw_ready;

    diag = '0;
    for (int r = 0; r < 16; r++) diag[16*r + r] = 1'b1;
    diag[17] = 1'b1;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0001, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0001, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0001, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0001, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 16'hFFFD, 16'h0002, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'hFFFD, 16'h0002, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 16'hFFFD, 16'h0002, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 16'hFFFD, 16'h0002, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0001, 1'b1, 1'b0, 1'b1};

    // Table: reset, idle load of the diagonal frame, start-up timing, disable/restart.
    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].rst, tbl[i].en, tbl[i].v, tbl[i].v ? diag : '0);
      n_vec++;
      if (R !== tbl[i].r || C !== tbl[i].c || frame_ready !== tbl[i].rdy ||
          step_req !== tbl[i].st || frame_start !== tbl[i].fs) begin
        n_bad++;
        $display("FAIL tbl[%0d]: R=%h C=%h rdy=%b step=%b fs=%b, required R=%h C=%h rdy=%b step=%b fs=%b",
                 i, R, C, frame_ready, step_req, frame_start,
                 tbl[i].r, tbl[i].c, tbl[i].rdy, tbl[i].st, tbl[i].fs);
      end
    end

    // Diagonal frame: each row r shows column r only.
    for (int r = 1; r < 16; r++) begin
      wait_row(r, "diag_row");
      chk("diag_col", C, 32'(16'h0001 << r));
    end

    // Nine frames: step_req exactly three times, 288 cycles apart, at row15 -> BLANK.
    tick(1'b1, 1'b0, 1'b0, '0);
    nstep = 0; nfs = 0;
    for (int kk = 1; kk <= 9 * FRAME + 2; kk++) begin
      prev_r = R;
      tick(1'b0, 1'b1, 1'b0, '0);
      if (frame_start) nfs++;
      if (step_req) begin
        chk("step_at_cycle", kk, 288 * (nstep + 1) + 1);
        chk("step_prev_row15", prev_r, 16'h7FFF);
        chk("step_now_blank", R, 16'hFFFF);
        nstep++;
      end
    end
    chk("step_count", nstep, 3);
    chk("frame_start_count", nfs, 9);

    // Double buffering: B offered mid-frame, C held off until after frame end.
    fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b1, fa);
    chk("a_accept_ready", frame_ready, 0);
    tick(1'b0, 1'b0, 1'b0, '0);
    chk("a_idle_swap_ready", frame_ready, 1);
    tick(1'b0, 1'b1, 1'b0, '0);
    wait_row(0, "a_row0");
    chk("a_row0_col", C, 32'(fa[15:0]));
    wait_row(3, "b_row3");
    tick(1'b0, 1'b1, 1'b1, fb);
    chk("b_accept_ready", frame_ready, 0);
    k = 0; saw_ready = 1'b0;
    while (!frame_start && k < 200) begin
      prev_r = R;
      tick(1'b0, 1'b1, 1'b1, fc);
      k++;
      if (frame_ready) begin
        saw_ready = 1'b1;
        chk("c_ready_after_frame_end", prev_r, 16'h7FFF);
      end
    end
    chk("b_frame_start_seen", frame_start, 1);
    chk("c_ready_seen", saw_ready, 1);
    chk("b_row0_col", C, 32'(fb[15:0]));
    chk("c_pending_ready", frame_ready, 0);
    k = 0;
    do begin
      tick(1'b0, 1'b1, 1'b0, '0);
      k++;
    end while (!frame_start && k < 200);
    chk("c_frame_start_seen", frame_start, 1);
    chk("c_row0_col", C, 32'(fc[15:0]));

    // Enable dropped during row 7, then restart.
    wait_row(7, "e_row7");
    tick(1'b0, 1'b0, 1'b0, '0);
    chk("e_off_r", R, 16'hFFFF);
    chk("e_off_c", C, 16'h0000);
    tick(1'b0, 1'b1, 1'b0, '0);
    chk("e_blank1", R, 16'hFFFF);
    tick(1'b0, 1'b1, 1'b0, '0);
    chk("e_blank2", R, 16'hFFFF);
    tick(1'b0, 1'b1, 1'b0, '0);
    chk("e_row0", R, 16'hFFFE);
    chk("e_fs", frame_start, 1);

    // Reset during row 10 with a frame pending.
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b1, '1);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    wait_row(2, "r_row2");
    tick(1'b0, 1'b1, 1'b1, rand_frame());
    chk("r_pending", frame_ready, 0);
    wait_row(10, "r_row10");
    chk("r_row10_col", C, 16'hFFFF);
    tick(1'b1, 1'b1, 1'b0, '0);
    chk("r_rst_r", R, 16'hFFFF);
    chk("r_rst_c", C, 16'h0000);
    chk("r_rst_ready", frame_ready, 1);
    chk("r_rst_step", step_req, 0);
    chk("r_rst_fs", frame_start, 0);
    chk("r_rst_state", dbg_state, 0);
    for (int i = 0; i < FRAME + 4; i++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      chk("r_cleared_c", C, 16'h0000);
    end

    // Random traffic against the model.
    tick(1'b1, 1'b0, 1'b0, '0);
    fa = rand_frame();
    for (int i = 0; i < 6000; i++) begin
      logic r, e, v;
      r = ($urandom_range(0, 1999) == 0);
      e = ($urandom_range(0, 249) != 0);
      v = ($urandom_range(0, 2) == 0);
      if (v && !m_pend && !r) begin
        tick(r, e, v, fa);
        fa = rand_frame();
      end else begin
        tick(r, e, v, fa);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
